// File: rtl/alu_pkg.sv
// Shared opcode, width and FSM definitions for the ALU command sequencer.
package alu_pkg;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned SHIFT_W  = 5;

    localparam logic [OPCODE_W-1:0] ADD = 4'd0;
    localparam logic [OPCODE_W-1:0] SUB = 4'd1;
    localparam logic [OPCODE_W-1:0] AND = 4'd2;
    localparam logic [OPCODE_W-1:0] OR  = 4'd3;
    localparam logic [OPCODE_W-1:0] SLT = 4'd4;
    localparam logic [OPCODE_W-1:0] SGT = 4'd5;
    localparam logic [OPCODE_W-1:0] SNE = 4'd6;
    localparam logic [OPCODE_W-1:0] MAX = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with extra-MSB pointers; exposes current and
// next-cycle full/empty so the owner can register its status outputs.
module alu_cmd_fifo #(
    parameter int unsigned DATA_W = 41,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic              full_nxt,
    output logic              empty_nxt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push, do_pop;

    always_comb begin
        full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        empty     = (wptr_q == rptr_q);
        do_push   = push && !full;
        do_pop    = pop && !empty;
        wptr_d    = wptr_q + PW'(do_push);
        rptr_d    = rptr_q + PW'(do_pop);
        full_nxt  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
        empty_nxt = (wptr_d == rptr_d);
        head_data = mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: entries are only visible between push and pop.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Buffers ALU commands, issues them one at a time with stable operands,
// and returns captured result/carry in command order.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned NUM_OPS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [OPCODE_W-1:0] cmd_opcode,
    input  logic [WIDTH-1:0]    cmd_a,
    input  logic [WIDTH-1:0]    cmd_b,
    input  logic [SHIFT_W-1:0]  cmd_shift,
    output logic [OPCODE_W-1:0] alu_opcode,
    output logic [WIDTH-1:0]    alu_input1,
    output logic [WIDTH-1:0]    alu_input2,
    output logic [SHIFT_W-1:0]  alu_shiftValue,
    input  logic [WIDTH-1:0]    alu_result,
    input  logic                alu_carryFlag,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WIDTH-1:0]    rsp_result,
    output logic                rsp_carry,
    output logic [OPCODE_W-1:0] rsp_opcode,
    output logic                rsp_illegal,
    output logic                busy,
    output logic [15:0]         done_count
);

    localparam int unsigned CMD_W = OPCODE_W + 2 * WIDTH + SHIFT_W;

    seq_state_e          state_q, state_d;
    logic [OPCODE_W-1:0] alu_opcode_q, alu_opcode_d;
    logic [WIDTH-1:0]    alu_input1_q, alu_input1_d;
    logic [WIDTH-1:0]    alu_input2_q, alu_input2_d;
    logic [SHIFT_W-1:0]  alu_shift_q, alu_shift_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]    rsp_result_q, rsp_result_d;
    logic                rsp_carry_q, rsp_carry_d;
    logic [OPCODE_W-1:0] rsp_opcode_q, rsp_opcode_d;
    logic                rsp_illegal_q, rsp_illegal_d;
    logic                busy_q, busy_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic [15:0]         done_count_q, done_count_d;

    logic [CMD_W-1:0]    push_data, head_data;
    logic                fifo_push, fifo_pop;
    logic                fifo_full, fifo_empty, fifo_full_nxt, fifo_empty_nxt;
    logic                illegal;

    assign push_data = {cmd_opcode, cmd_a, cmd_b, cmd_shift};
    assign fifo_push = cmd_valid && cmd_ready_q;

    alu_cmd_fifo #(
        .DATA_W (CMD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .push_data (push_data),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .full_nxt  (fifo_full_nxt),
        .empty_nxt (fifo_empty_nxt)
    );

    // Next-state and output logic; a pop always reloads the ALU operand registers.
    always_comb begin
        state_d       = state_q;
        alu_opcode_d  = alu_opcode_q;
        alu_input1_d  = alu_input1_q;
        alu_input2_d  = alu_input2_q;
        alu_shift_d   = alu_shift_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_carry_d   = rsp_carry_q;
        rsp_opcode_d  = rsp_opcode_q;
        rsp_illegal_d = rsp_illegal_q;
        done_count_d  = done_count_q;
        fifo_pop      = 1'b0;
        illegal       = (32'(alu_opcode_q) >= NUM_OPS);

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                rsp_valid_d   = 1'b1;
                rsp_opcode_d  = alu_opcode_q;
                rsp_illegal_d = illegal;
                rsp_result_d  = illegal ? '0 : alu_result;
                rsp_carry_d   = illegal ? 1'b0 : alu_carryFlag;
                state_d       = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                    done_count_d = done_count_q + 16'd1;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_WAIT;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (fifo_pop) begin
            alu_opcode_d = head_data[CMD_W-1 -: OPCODE_W];
            alu_input1_d = head_data[SHIFT_W+2*WIDTH-1 -: WIDTH];
            alu_input2_d = head_data[SHIFT_W+WIDTH-1 -: WIDTH];
            alu_shift_d  = head_data[SHIFT_W-1:0];
        end

        busy_d      = !fifo_empty_nxt || (state_d != ST_IDLE);
        cmd_ready_d = !fifo_full_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            alu_opcode_q  <= '0;
            alu_input1_q  <= '0;
            alu_input2_q  <= '0;
            alu_shift_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_carry_q   <= 1'b0;
            rsp_opcode_q  <= '0;
            rsp_illegal_q <= 1'b0;
            busy_q        <= 1'b0;
            cmd_ready_q   <= 1'b0;
            done_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            alu_opcode_q  <= alu_opcode_d;
            alu_input1_q  <= alu_input1_d;
            alu_input2_q  <= alu_input2_d;
            alu_shift_q   <= alu_shift_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_carry_q   <= rsp_carry_d;
            rsp_opcode_q  <= rsp_opcode_d;
            rsp_illegal_q <= rsp_illegal_d;
            busy_q        <= busy_d;
            cmd_ready_q   <= cmd_ready_d;
            done_count_q  <= done_count_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign alu_opcode     = alu_opcode_q;
    assign alu_input1     = alu_input1_q;
    assign alu_input2     = alu_input2_q;
    assign alu_shiftValue = alu_shift_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_result     = rsp_result_q;
    assign rsp_carry      = rsp_carry_q;
    assign rsp_opcode     = rsp_opcode_q;
    assign rsp_illegal    = rsp_illegal_q;
    assign busy           = busy_q;
    assign done_count     = done_count_q;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command-side driver for the generated combinational ALUs (opcode/input1/input2/shiftValue in, result/carryFlag out).
- Accepts operation commands over a valid/ready interface and buffers them in a small FIFO.
- Issues each command to an attached ALU instance with registered, stable operands, captures result and carry, and returns them over a valid/ready response interface.
- Used by the ALU regression harness and by any datapath that time-shares one ALU.

Parameters:
- WIDTH, 16, operand/result width; matches the attached ALU.
- DEPTH, 4, command FIFO entries; power of two, ≥2.
- NUM_OPS, 8, number of legal opcodes (0..NUM_OPS-1); higher opcodes are illegal.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept.
- cmd_opcode  in  4  ALU opcode.
- cmd_a  in  WIDTH  operand 1.
- cmd_b  in  WIDTH  operand 2.
- cmd_shift  in  5  shift amount.
- alu_opcode  out  4  to ALU opcode.
- alu_input1  out  WIDTH  to ALU input1.
- alu_input2  out  WIDTH  to ALU input2.
- alu_shiftValue  out  5  to ALU shiftValue.
- alu_result  in  WIDTH  from ALU result.
- alu_carryFlag  in  1  from ALU carryFlag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts.
- rsp_result  out  WIDTH  captured result.
- rsp_carry  out  1  captured carry.
- rsp_opcode  out  4  opcode of this response.
- rsp_illegal  out  1  opcode was ≥ NUM_OPS.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- done_count  out  16  completed responses, wraps 0xFFFF→0x0000.

Behaviour:
- Reset: asynchronous and active-high. It clears the FIFO, state=IDLE, and forces all alu_*, rsp_*, busy and done_count to 0. cmd_ready is 0 while rst is high and 1 on the first cycle after release. In-flight and buffered commands are dropped.
- Command push: occurs on edge with cmd_valid && cmd_ready.
  - cmd_ready = !fifo_full; there is no push-when-full bypass.
  - Push and pop in the same cycle are legal whenever not full.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If the FIFO is non-empty, pop the head, register it into alu_* outputs, and go to WAIT.
  - There is no same-cycle bypass: a command pushed into an empty FIFO is popped on the following edge.
- WAIT (one cycle, ALU settle): on the next edge, capture into rsp_* registers, set rsp_valid=1, go to RESP.
  - rsp_result ← alu_result, rsp_carry ← alu_carryFlag.
  - If alu_opcode ≥ NUM_OPS: rsp_result=0, rsp_carry=0, rsp_illegal=1. The opcode is still driven to the ALU unchanged.
- RESP:
  - rsp_* hold stable while rsp_valid && !rsp_ready.
  - On handshake, done_count increments and rsp_valid drops.
  - If the FIFO is non-empty, pop and load alu_* in the same edge and go to WAIT; otherwise go to IDLE.
- Latency: push edge E0 → alu_* valid after E1 → rsp_valid high after E2 (2 cycles). Sustained throughput is 1 op per 2 cycles with rsp_ready held high.
- alu_* outputs hold their last issued values until the next pop; they never glitch mid-operation.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. full/empty come from the MSB compare.
- Ordering: responses are returned strictly in command order.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams ADD=0, SUB=1, AND=2, OR=3, SLT=4, SGT=5, SNE=6, MAX=7;
  - OPCODE_W=4, SHIFT_W=5;
  - FSM state encoding.
- One sub-module, alu_cmd_fifo: synchronous FIFO, width 4+2*WIDTH+5, depth DEPTH, with push/pop/full/empty.

Test Plan:
- The bench ties the outputs to a behavioural ALU model with carryFlag = bit 16 of the 17-bit add/sub.
- Push ADD a=0xFFFF b=0x0001 → rsp_valid exactly 2 cycles after the push edge; rsp_result=0x0000, rsp_carry=1, rsp_opcode=0, rsp_illegal=0, done_count=1 after handshake.
- Push SUB 0x0005,0x0007 then MAX 0x1234,0x8000 back-to-back, rsp_ready=1 → in-order responses 0xFFFE carry=1, then 0x8000; alu_* stable throughout each WAIT.
- Hold rsp_ready=0 and push 5 commands (DEPTH=4) → cmd_ready drops after the 4th FIFO entry (one in flight). The first response is held stable. Releasing rsp_ready drains all 5 in order.
- Push opcode 0xA, a=0x00FF, b=0xFF00 → rsp_illegal=1, rsp_result=0x0000, rsp_carry=0, rsp_opcode=0xA.
- Assert rst during WAIT with 2 commands queued → all outputs go to 0 asynchronously. After release: cmd_ready=1, busy=0, no stale response appears, and the next push completes normally.
- Preload done_count to 0xFFFF via 65535 AND ops (or force), then complete one more → done_count=0x0000.
